// File: rtl/sram_like_arbiter_if.sv
// SRAM-like bus bundle; NCH lanes of request signals, one shared rdata.
// The arbiter's upstream side uses NCH=NUM_CH, its downstream side NCH=1.
interface sram_like_arbiter_if #(
  parameter int unsigned NCH     = 1,
  parameter int unsigned ADDR_WD = 32,
  parameter int unsigned DATA_WD = 32
);
  logic [NCH-1:0]           req;
  logic [NCH-1:0]           wr;
  logic [2*NCH-1:0]         size;
  logic [NCH*DATA_WD/8-1:0] wstrb;
  logic [NCH*ADDR_WD-1:0]   addr;
  logic [NCH*DATA_WD-1:0]   wdata;
  logic [NCH-1:0]           addr_ok;
  logic [NCH-1:0]           data_ok;
  logic [DATA_WD-1:0]       rdata;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_like_arbiter.sv
// N-channel SRAM-like arbiter with an in-order channel-ID FIFO for
// response routing and an outstanding-transaction limit.
module sram_like_arbiter #(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned ADDR_WD   = 32,
  parameter int unsigned DATA_WD   = 32,
  parameter int unsigned MAX_OUTST = 4,
  parameter int unsigned ARB_MODE  = 0
) (
  input  logic                clk,
  input  logic                reset,
  sram_like_arbiter_if.slave  s,
  sram_like_arbiter_if.master m
);
  localparam int unsigned ID_WD   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned PTR_WD  = $clog2(MAX_OUTST);
  localparam int unsigned CNT_WD  = PTR_WD + 1;
  localparam int unsigned STRB_WD = DATA_WD / 8;

  typedef enum logic {ST_OPEN, ST_LOCKED} state_e;

  state_e            state_q, state_d;
  logic [ID_WD-1:0]  grant_q, grant_d;
  logic [ID_WD-1:0]  last_q, last_d;
  logic [ID_WD-1:0]  fifo_q [MAX_OUTST];
  logic [ID_WD-1:0]  fifo_d [MAX_OUTST];
  logic [PTR_WD-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_WD-1:0] count_q, count_d;

  logic              full, empty, push, pop, req_sel;
  logic [ID_WD-1:0]  head;
  logic [NUM_CH-1:0] grant_oh, head_oh;

  // While locked the registered grant is reused so m_* stays stable.
  always_comb begin
    logic        found;
    int unsigned idx;
    found   = 1'b0;
    idx     = 0;
    grant_d = grant_q;
    if (state_q == ST_OPEN) begin
      grant_d = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        idx = (ARB_MODE == 1) ? i : (32'(last_q) + 1 + i) % NUM_CH;
        if (!found && ((s.req & (NUM_CH'(1) << idx)) != '0)) begin
          found   = 1'b1;
          grant_d = ID_WD'(idx);
        end
      end
    end
  end

  assign grant_oh  = NUM_CH'(1) << grant_d;
  assign full      = (count_q == CNT_WD'(MAX_OUTST));
  assign empty     = (count_q == '0);
  assign req_sel   = |(s.req & grant_oh);
  assign m.req     = ~reset & req_sel & ~full;
  assign push      = m.req & m.addr_ok;
  assign head      = fifo_q[rd_ptr_q];
  assign head_oh   = NUM_CH'(1) << head;
  assign pop       = ~reset & m.data_ok & ~empty;
  assign s.addr_ok = push ? grant_oh : '0;
  assign s.data_ok = pop ? head_oh : '0;
  assign s.rdata   = m.rdata;

  always_comb begin
    m.wr    = '0;
    m.size  = '0;
    m.wstrb = '0;
    m.addr  = '0;
    m.wdata = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (grant_d == ID_WD'(i)) begin
        m.wr    = s.wr[i];
        m.size  = s.size[2*i +: 2];
        m.wstrb = s.wstrb[i*STRB_WD +: STRB_WD];
        m.addr  = s.addr[i*ADDR_WD +: ADDR_WD];
        m.wdata = s.wdata[i*DATA_WD +: DATA_WD];
      end
    end
  end

  // Pop reads the old head before a same-cycle push lands in the FIFO.
  always_comb begin
    state_d  = (m.req & ~m.addr_ok) ? ST_LOCKED : ST_OPEN;
    last_d   = (push && ARB_MODE == 0) ? grant_d : last_q;
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      fifo_d[wr_ptr_q] = grant_d;
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_OPEN;
      grant_q  <= '0;
      last_q   <= ID_WD'(NUM_CH - 1);
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      fifo_q   <= fifo_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: tb/tb_sram_like_arbiter.sv
// Bench for sram_like_arbiter: RR and fixed-priority instances share stimulus;
// directed vector table, hand sequences, then random traffic against a queue model.
module tb_sram_like_arbiter;
  localparam int NCH  = 2;
  localparam int MAXO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req, wr;
  logic [3:0]  size;
  logic [7:0]  wstrb;
  logic [63:0] addr, wdata;
  logic        aok, dok;
  logic [31:0] rdata;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sram_like_arbiter_if #(.NCH(2), .ADDR_WD(32), .DATA_WD(32)) s_rr ();
  sram_like_arbiter_if #(.NCH(1), .ADDR_WD(32), .DATA_WD(32)) m_rr ();
  sram_like_arbiter_if #(.NCH(2), .ADDR_WD(32), .DATA_WD(32)) s_fp ();
  sram_like_arbiter_if #(.NCH(1), .ADDR_WD(32), .DATA_WD(32)) m_fp ();

  assign s_rr.req = req;   assign s_fp.req = req;
  assign s_rr.wr = wr;     assign s_fp.wr = wr;
  assign s_rr.size = size; assign s_fp.size = size;
  assign s_rr.wstrb = wstrb; assign s_fp.wstrb = wstrb;
  assign s_rr.addr = addr; assign s_fp.addr = addr;
  assign s_rr.wdata = wdata; assign s_fp.wdata = wdata;
  assign m_rr.addr_ok = aok; assign m_fp.addr_ok = aok;
  assign m_rr.data_ok = dok; assign m_fp.data_ok = dok;
  assign m_rr.rdata = rdata; assign m_fp.rdata = rdata;

  sram_like_arbiter #(.NUM_CH(2), .ADDR_WD(32), .DATA_WD(32), .MAX_OUTST(4), .ARB_MODE(0)) u_rr (
    .clk(clk), .reset(reset), .s(s_rr), .m(m_rr)
  );
  sram_like_arbiter #(.NUM_CH(2), .ADDR_WD(32), .DATA_WD(32), .MAX_OUTST(4), .ARB_MODE(1)) u_fp (
    .clk(clk), .reset(reset), .s(s_fp), .m(m_fp)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] r, input logic a, input logic d,
                       input logic [31:0] rd, input logic [31:0] a0, input logic [31:0] a1);
    @(posedge clk); #1;
    req = r; aok = a; dok = d; rdata = rd; addr = {a1, a0};
    #4;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; req = '0; aok = 1'b0; dok = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // ---------------- behavioural reference model ----------------
  int idq [2][$];
  int last_m [2];
  bit lock_m [2];
  int held_m [2];

  task automatic model_reset(input int mode);
    idq[mode].delete();
    last_m[mode] = NCH - 1;
    lock_m[mode] = 1'b0;
    held_m[mode] = 0;
  endtask

  task automatic model_cycle(input int mode);
    int g, c;
    bit found, e_mreq, hs, pp;
    logic [1:0] e_aok, e_dok;
    logic a_mreq;
    logic [1:0] a_aok, a_dok;
    logic [31:0] a_rdata, a_addr, a_wdata;
    logic a_wr;
    logic [1:0] a_size;
    logic [3:0] a_wstrb;
    string p;
    p = (mode == 1) ? "fp" : "rr";
    a_mreq  = (mode == 1) ? m_fp.req[0] : m_rr.req[0];
    a_aok   = (mode == 1) ? s_fp.addr_ok : s_rr.addr_ok;
    a_dok   = (mode == 1) ? s_fp.data_ok : s_rr.data_ok;
    a_rdata = (mode == 1) ? s_fp.rdata : s_rr.rdata;
    a_addr  = (mode == 1) ? m_fp.addr : m_rr.addr;
    a_wdata = (mode == 1) ? m_fp.wdata : m_rr.wdata;
    a_wr    = (mode == 1) ? m_fp.wr[0] : m_rr.wr[0];
    a_size  = (mode == 1) ? m_fp.size : m_rr.size;
    a_wstrb = (mode == 1) ? m_fp.wstrb : m_rr.wstrb;

    found = 1'b0; g = 0;
    if (lock_m[mode]) begin
      g = held_m[mode];
      found = req[g];
    end else begin
      for (int k = 0; k < NCH; k++) begin
        c = (mode == 1) ? k : (last_m[mode] + 1 + k) % NCH;
        if (!found && req[c]) begin found = 1'b1; g = c; end
      end
    end
    e_mreq = found && (idq[mode].size() < MAXO) && !reset;
    hs     = e_mreq && aok;
    pp     = dok && (idq[mode].size() > 0) && !reset;
    e_aok  = hs ? 2'(1 << g) : 2'b00;
    e_dok  = pp ? 2'(1 << idq[mode][0]) : 2'b00;

    chk({p, "_rnd_mreq"}, 64'(a_mreq), 64'(e_mreq));
    chk({p, "_rnd_addr_ok"}, 64'(a_aok), 64'(e_aok));
    chk({p, "_rnd_data_ok"}, 64'(a_dok), 64'(e_dok));
    chk({p, "_rnd_rdata"}, 64'(a_rdata), 64'(rdata));
    if (e_mreq && a_mreq) begin
      chk({p, "_rnd_maddr"}, 64'(a_addr), 64'(addr[g*32 +: 32]));
      chk({p, "_rnd_mwdata"}, 64'(a_wdata), 64'(wdata[g*32 +: 32]));
      chk({p, "_rnd_mctl"}, {57'd0, a_wr, a_size, a_wstrb},
          {57'd0, wr[g], size[g*2 +: 2], wstrb[g*4 +: 4]});
    end

    if (reset) begin
      model_reset(mode);
    end else begin
      if (pp) void'(idq[mode].pop_front());
      if (hs) begin
        idq[mode].push_back(g);
        if (mode == 0) last_m[mode] = g;
      end
      lock_m[mode] = e_mreq && !aok;
      held_m[mode] = g;
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [1:0]  req;
    logic        aok;
    logic        dok;
    logic [31:0] rd;
    logic [31:0] a0;
    logic [31:0] a1;
    logic        emreq;
    logic [1:0]  eaok;
    logic [1:0]  edok;
    logic [31:0] emaddr;
  } vec_t;

  vec_t vt [16];

  initial begin
    reset = 1'b1; req = '0; wr = '0; size = '0; wstrb = '0; addr = '0; wdata = '0;
    aok = 1'b0; dok = 1'b0; rdata = '0;

    // RR fairness, outstanding limit, drain, empty error, ordering with push/pop overlap
    vt[0]  = '{2'b11, 1'b1, 1'b0, 32'h0, 32'h100, 32'h200, 1'b1, 2'b01, 2'b00, 32'h100};
    vt[1]  = '{2'b11, 1'b1, 1'b0, 32'h0, 32'h100, 32'h200, 1'b1, 2'b10, 2'b00, 32'h200};
    vt[2]  = '{2'b11, 1'b1, 1'b0, 32'h0, 32'h100, 32'h200, 1'b1, 2'b01, 2'b00, 32'h100};
    vt[3]  = '{2'b11, 1'b1, 1'b0, 32'h0, 32'h100, 32'h200, 1'b1, 2'b10, 2'b00, 32'h200};
    vt[4]  = '{2'b11, 1'b1, 1'b1, 32'hA, 32'h100, 32'h200, 1'b0, 2'b00, 2'b01, 32'h0};
    vt[5]  = '{2'b11, 1'b1, 1'b0, 32'h0, 32'h100, 32'h200, 1'b1, 2'b01, 2'b00, 32'h100};
    vt[6]  = '{2'b11, 1'b1, 1'b1, 32'hB, 32'h100, 32'h200, 1'b0, 2'b00, 2'b10, 32'h0};
    vt[7]  = '{2'b00, 1'b0, 1'b1, 32'hC, 32'h100, 32'h200, 1'b0, 2'b00, 2'b01, 32'h0};
    vt[8]  = '{2'b00, 1'b0, 1'b1, 32'hD, 32'h100, 32'h200, 1'b0, 2'b00, 2'b10, 32'h0};
    vt[9]  = '{2'b00, 1'b0, 1'b1, 32'hE, 32'h100, 32'h200, 1'b0, 2'b00, 2'b01, 32'h0};
    vt[10] = '{2'b00, 1'b0, 1'b1, 32'hF, 32'h100, 32'h200, 1'b0, 2'b00, 2'b00, 32'h0};
    vt[11] = '{2'b01, 1'b1, 1'b0, 32'h0, 32'h100, 32'h200, 1'b1, 2'b01, 2'b00, 32'h100};
    vt[12] = '{2'b10, 1'b1, 1'b1, 32'hA, 32'h100, 32'h200, 1'b1, 2'b10, 2'b01, 32'h200};
    vt[13] = '{2'b01, 1'b1, 1'b1, 32'hB, 32'h300, 32'h200, 1'b1, 2'b01, 2'b10, 32'h300};
    vt[14] = '{2'b00, 1'b0, 1'b1, 32'hC, 32'h300, 32'h200, 1'b0, 2'b00, 2'b01, 32'h0};
    vt[15] = '{2'b00, 1'b0, 1'b1, 32'hD, 32'h300, 32'h200, 1'b0, 2'b00, 2'b00, 32'h0};

    @(posedge clk); #1;
    #4;
    chk("reset_mreq", 64'(m_rr.req), 64'd0);
    chk("reset_addr_ok", 64'(s_rr.addr_ok), 64'd0);
    chk("reset_data_ok", 64'(s_rr.data_ok), 64'd0);
    do_reset();

    for (int i = 0; i < 16; i++) begin
      drive(vt[i].req, vt[i].aok, vt[i].dok, vt[i].rd, vt[i].a0, vt[i].a1);
      chk($sformatf("vec%0d_mreq", i), 64'(m_rr.req), 64'(vt[i].emreq));
      chk($sformatf("vec%0d_addr_ok", i), 64'(s_rr.addr_ok), 64'(vt[i].eaok));
      chk($sformatf("vec%0d_data_ok", i), 64'(s_rr.data_ok), 64'(vt[i].edok));
      chk($sformatf("vec%0d_rdata", i), 64'(s_rr.rdata), 64'(vt[i].rd));
      if (vt[i].emreq) chk($sformatf("vec%0d_maddr", i), 64'(m_rr.addr), 64'(vt[i].emaddr));
    end

    // Lock/stall: ch1 stalls 3 cycles, ch0 arrives during the stall
    do_reset();
    drive(2'b10, 1'b0, 1'b0, 32'h0, 32'h100, 32'h200);
    chk("lock_c1_mreq", 64'(m_rr.req), 64'd1);
    chk("lock_c1_maddr", 64'(m_rr.addr), 64'h200);
    drive(2'b11, 1'b0, 1'b0, 32'h0, 32'h100, 32'h200);
    chk("lock_c2_maddr", 64'(m_rr.addr), 64'h200);
    chk("lock_c2_addr_ok", 64'(s_rr.addr_ok), 64'd0);
    drive(2'b11, 1'b0, 1'b0, 32'h0, 32'h100, 32'h200);
    chk("lock_c3_maddr", 64'(m_rr.addr), 64'h200);
    drive(2'b11, 1'b1, 1'b0, 32'h0, 32'h100, 32'h200);
    chk("lock_hs_maddr", 64'(m_rr.addr), 64'h200);
    chk("lock_hs_addr_ok", 64'(s_rr.addr_ok), 64'b10);
    drive(2'b01, 1'b1, 1'b0, 32'h0, 32'h100, 32'h200);
    chk("lock_next_addr_ok", 64'(s_rr.addr_ok), 64'b01);
    chk("lock_next_maddr", 64'(m_rr.addr), 64'h100);

    // Fixed priority: ch0 wins until it drops, then ch1 granted same cycle
    do_reset();
    drive(2'b11, 1'b1, 1'b1, 32'h0, 32'h100, 32'h200);
    chk("fp_c0_addr_ok", 64'(s_fp.addr_ok), 64'b01);
    chk("fp_c0_data_ok", 64'(s_fp.data_ok), 64'b00);
    drive(2'b11, 1'b1, 1'b1, 32'h0, 32'h100, 32'h200);
    chk("fp_c1_addr_ok", 64'(s_fp.addr_ok), 64'b01);
    chk("fp_c1_data_ok", 64'(s_fp.data_ok), 64'b01);
    drive(2'b11, 1'b1, 1'b1, 32'h0, 32'h100, 32'h200);
    chk("fp_c2_addr_ok", 64'(s_fp.addr_ok), 64'b01);
    drive(2'b10, 1'b1, 1'b1, 32'h0, 32'h100, 32'h200);
    chk("fp_drop_addr_ok", 64'(s_fp.addr_ok), 64'b10);
    chk("fp_drop_maddr", 64'(m_fp.addr), 64'h200);
    chk("fp_drop_data_ok", 64'(s_fp.data_ok), 64'b01);
    drive(2'b00, 1'b0, 1'b1, 32'h0, 32'h100, 32'h200);
    chk("fp_last_data_ok", 64'(s_fp.data_ok), 64'b10);

    // Reset mid-flight: two outstanding, reset, late data_ok ignored
    do_reset();
    drive(2'b01, 1'b1, 1'b0, 32'h0, 32'h100, 32'h200);
    drive(2'b01, 1'b1, 1'b0, 32'h0, 32'h100, 32'h200);
    chk("rmf_pre_addr_ok", 64'(s_rr.addr_ok), 64'b01);
    @(posedge clk); #1;
    reset = 1'b1; req = 2'b11; aok = 1'b1; dok = 1'b1;
    #4;
    chk("rmf_rst_mreq", 64'(m_rr.req), 64'd0);
    chk("rmf_rst_addr_ok", 64'(s_rr.addr_ok), 64'd0);
    chk("rmf_rst_data_ok", 64'(s_rr.data_ok), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0; req = 2'b00; aok = 1'b0; dok = 1'b1;
    #4;
    chk("rmf_late_data_ok", 64'(s_rr.data_ok), 64'd0);
    for (int i = 0; i < 4; i++) begin
      drive(2'b11, 1'b1, 1'b0, 32'h0, 32'h100, 32'h200);
      chk($sformatf("rmf_fill%0d_addr_ok", i), 64'(s_rr.addr_ok), (i % 2 == 0) ? 64'b01 : 64'b10);
    end
    drive(2'b11, 1'b1, 1'b0, 32'h0, 32'h100, 32'h200);
    chk("rmf_full_mreq", 64'(m_rr.req), 64'd0);

    // Random traffic against the reference model (both arbitration modes)
    do_reset();
    model_reset(0);
    model_reset(1);
    for (int n = 0; n < 800; n++) begin
      @(posedge clk); #1;
      reset = ($urandom_range(0, 79) == 0);
      req   = 2'($urandom);
      wr    = 2'($urandom);
      size  = 4'($urandom);
      wstrb = 8'($urandom);
      addr  = {$urandom, $urandom};
      wdata = {$urandom, $urandom};
      aok   = ($urandom_range(0, 9) < 7);
      dok   = 1'($urandom);
      rdata = $urandom;
      #4;
      model_cycle(0);
      model_cycle(1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end
endmodule

// File: doc/sram_like_arbiter.md
Name: sram_like_arbiter

Overview:
- N-channel arbiter merging several SRAM-like masters onto one SRAM-like slave port. Typical masters: the fetch stage, the load/store stage, and later a cache refill engine.
- Sits between the CPU core and the AXI bridge or memory.
- Supports multiple outstanding transactions with in-order responses.
- Response routing uses an ordered channel-ID FIFO.

Parameters:
- NUM_CH, 2, number of upstream channels (1..8).
- ADDR_WD, 32, address width.
- DATA_WD, 32, data width; wstrb width is DATA_WD/8.
- MAX_OUTST, 4, max outstanding accepted-but-unanswered transactions (power of 2, ≥2).
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (channel 0 highest).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- s_req  in  NUM_CH  per-channel request.
- s_wr  in  NUM_CH  per-channel write flag.
- s_size  in  2*NUM_CH  per-channel size (0 = byte, 1 = half, 2 = word).
- s_wstrb  in  NUM_CH*DATA_WD/8  per-channel byte strobes.
- s_addr  in  NUM_CH*ADDR_WD  per-channel address.
- s_wdata  in  NUM_CH*DATA_WD  per-channel write data.
- s_addr_ok  out  NUM_CH  per-channel request accepted.
- s_data_ok  out  NUM_CH  per-channel response.
- s_rdata  out  DATA_WD  read data, broadcast to all channels.
- m_req  out  1  downstream request.
- m_wr  out  1  downstream write flag.
- m_size  out  2  downstream size.
- m_wstrb  out  DATA_WD/8  downstream strobes.
- m_addr  out  ADDR_WD  downstream address.
- m_wdata  out  DATA_WD  downstream write data.
- m_addr_ok  in  1  downstream accept.
- m_data_ok  in  1  downstream response.
- m_rdata  in  DATA_WD  downstream read data.

Behaviour:
- Reset: clears the ID FIFO (empty, count 0), round-robin pointer (last = NUM_CH-1), and the lock flag. While reset is high, m_req, s_addr_ok and s_data_ok are forced to 0.
- Grant:
  - Grant is combinational from s_req when unlocked.
  - RR mode: search starts at last+1 and wraps modulo NUM_CH.
  - Fixed mode: lowest index wins.
- Lock:
  - Set when m_req=1 and m_addr_ok=0. The registered grant is then held until handshake, so m_* stays stable.
  - Cleared on handshake.
  - While locked, new higher-priority requests do not preempt.
- Request path:
  - m_req = s_req[grant] & ~full.
  - m_wr, m_size, m_wstrb, m_addr and m_wdata are muxed from the granted channel. They are don't-care when m_req=0.
- Accept path:
  - s_addr_ok[grant] = m_addr_ok & m_req; all other channels get 0.
  - On handshake (m_req & m_addr_ok): push the grant ID to the FIFO, and in RR mode set last = grant.
- Full:
  - full = (count == MAX_OUTST). Conservative rule: no request is issued when full, even if a pop occurs in the same cycle.
  - When not full, a push and a pop in the same cycle keep the count unchanged.
- Response path:
  - s_data_ok[fifo_head] = m_data_ok & ~empty; pop on the same condition.
  - s_rdata = m_rdata, combinational, zero added latency.
  - Responses are returned strictly in acceptance order.
- Empty: m_data_ok while the FIFO is empty is a protocol error. It is ignored: no s_data_ok, no pointer change.
- Same-cycle data_ok and addr_ok: allowed; the response goes to the old head before the push takes effect.
- Pointers: ID width is max(1, clog2(NUM_CH)). FIFO pointers wrap modulo MAX_OUTST; count width is clog2(MAX_OUTST)+1.
- Reset mid-operation: all outstanding IDs are discarded. Downstream must also be reset; late m_data_ok after reset is ignored because the FIFO is empty.
- NUM_CH=1: degenerates to a pass-through with outstanding-limit gating.
- Latency: request path 0 cycles (combinational); response path 0 cycles.

Test Plan:
- RR fairness:
  - Stimulus: NUM_CH=2, both s_req held high, m_addr_ok=1 every cycle.
  - Required: grants alternate 0,1,0,1 starting with ch0 after reset; s_addr_ok alternates 01,10.
- Fixed priority (ARB_MODE=1):
  - Stimulus: both request continuously.
  - Required: only ch0 gets s_addr_ok until ch0 drops s_req, then ch1 is granted in the same cycle.
- Lock/stall:
  - Stimulus: ch1 requests alone with m_addr_ok=0 for 3 cycles; ch0 raises s_req in cycle 2.
  - Required: m_addr stays equal to ch1's address for all 3 cycles; ch1 gets addr_ok when m_addr_ok=1; ch0 is granted next.
- Outstanding limit (MAX_OUTST=4):
  - Stimulus: accept 4 requests with no m_data_ok.
  - Required: m_req=0 on the 5th despite s_req=1. After one m_data_ok (pop), m_req re-asserts the next cycle.
- Ordering and routing:
  - Stimulus: accept ch0 (addr 0x100), ch1 (0x200), ch0 (0x300); return rdata 0xA, 0xB, 0xC.
  - Required: s_data_ok pulses ch0, ch1, ch0 with s_rdata 0xA, 0xB, 0xC. Same-cycle push/pop keeps count correct.
- Reset mid-flight:
  - Stimulus: 2 outstanding, assert reset 1 cycle, then m_data_ok=1.
  - Required: no s_data_ok; count=0; RR restarts at ch0.
